// File: rtl/btc_pkg.sv
// rtl/btc_pkg.sv - shared constants, state encoding and byte-order helper for the double SHA-256 sequencer
package btc_pkg;

   localparam logic [255:0] SHA_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   // Message lengths in bits, written into the final 64 bits of each padded block
   localparam logic [63:0] BLK2_MSG_BITS = 64'd640;
   localparam logic [63:0] BLK3_MSG_BITS = 64'd256;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      B1_GO   = 3'd1,
      B1_WAIT = 3'd2,
      B2_GO   = 3'd3,
      B2_WAIT = 3'd4,
      B3_GO   = 3'd5,
      B3_WAIT = 3'd6
   } state_e;

   // Digest byte i lands in byte 31-i, turning the raw digest into the integer compared with target
   function automatic logic [255:0] byte_reverse(input logic [255:0] d);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[8*(31-i) +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/btc_double_sha256_ctrl_if.sv
// rtl/btc_double_sha256_ctrl_if.sv - job request/result and SHA core handshake bundle
interface btc_double_sha256_ctrl_if;

   logic         start;
   logic [639:0] header_in;
   logic [255:0] target;
   logic         busy;
   logic [255:0] hash_out;
   logic         hash_valid;
   logic         target_met;
   logic         sha_ready_to_hash;
   logic [511:0] sha_message;
   logic [255:0] sha_initial_hashes;
   logic [255:0] sha_digest;
   logic         sha_done;

   modport master (
      input  start, header_in, target, sha_digest, sha_done,
      output busy, hash_out, hash_valid, target_met,
             sha_ready_to_hash, sha_message, sha_initial_hashes
   );

   modport slave (
      output start, header_in, target, sha_digest, sha_done,
      input  busy, hash_out, hash_valid, target_met,
             sha_ready_to_hash, sha_message, sha_initial_hashes
   );

endinterface

// File: rtl/btc_block_padder.sv
// rtl/btc_block_padder.sv - builds the padded second header block and the padded digest block
module btc_block_padder
   import btc_pkg::*;
(
   input  logic [127:0] header_tail_i,
   input  logic [255:0] d1_i,
   output logic [511:0] blk2_o,
   output logic [511:0] blk3_o
);

   assign blk2_o = {header_tail_i, 1'b1, 319'b0, BLK2_MSG_BITS};
   assign blk3_o = {d1_i, 1'b1, 191'b0, BLK3_MSG_BITS};

endmodule

// File: rtl/btc_double_sha256_ctrl.sv
// rtl/btc_double_sha256_ctrl.sv - sequences three core passes to form the double SHA-256 of a block header
// Advances only on sha_done in a WAIT state; the core's latency is never assumed.
module btc_double_sha256_ctrl
   import btc_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   btc_double_sha256_ctrl_if.master  bus
);

   state_e       state_q;
   logic [127:0] header_tail_q;
   logic [255:0] target_q;
   logic         busy_q;
   logic         hash_valid_q;
   logic         target_met_q;
   logic [255:0] hash_out_q;
   logic         go_q;
   logic [511:0] msg_q;
   logic [255:0] iv_q;
   logic [511:0] blk2;
   logic [511:0] blk3;

   // d1 is taken straight from the core so block 3 is loaded on the same edge that ends block 2
   btc_block_padder u_padder (
      .header_tail_i (header_tail_q),
      .d1_i          (bus.sha_digest),
      .blk2_o        (blk2),
      .blk3_o        (blk3)
   );

   // Block 1 is loaded from header_in directly, so only the 128-bit tail needs to be kept.
   // iv_q holds the block-1 midstate during block 2 and msg_q holds d1 during block 3.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         header_tail_q <= '0;
         target_q      <= '0;
         busy_q        <= 1'b0;
         hash_valid_q  <= 1'b0;
         target_met_q  <= 1'b0;
         hash_out_q    <= '0;
         go_q          <= 1'b0;
         msg_q         <= '0;
         iv_q          <= '0;
      end else begin
         go_q         <= 1'b0;
         hash_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  header_tail_q <= bus.header_in[127:0];
                  target_q      <= bus.target;
                  busy_q        <= 1'b1;
                  msg_q         <= bus.header_in[639:128];
                  iv_q          <= SHA_IV;
                  go_q          <= 1'b1;
                  state_q       <= B1_GO;
               end
            end
            B1_GO: state_q <= B1_WAIT;
            B1_WAIT: begin
               if (bus.sha_done) begin
                  iv_q    <= bus.sha_digest;
                  msg_q   <= blk2;
                  go_q    <= 1'b1;
                  state_q <= B2_GO;
               end
            end
            B2_GO: state_q <= B2_WAIT;
            B2_WAIT: begin
               if (bus.sha_done) begin
                  iv_q    <= SHA_IV;
                  msg_q   <= blk3;
                  go_q    <= 1'b1;
                  state_q <= B3_GO;
               end
            end
            B3_GO: state_q <= B3_WAIT;
            B3_WAIT: begin
               if (bus.sha_done) begin
                  hash_out_q   <= bus.sha_digest;
                  target_met_q <= (byte_reverse(bus.sha_digest) <= target_q);
                  hash_valid_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy               = busy_q;
   assign bus.hash_out           = hash_out_q;
   assign bus.hash_valid         = hash_valid_q;
   assign bus.target_met         = target_met_q;
   assign bus.sha_ready_to_hash  = go_q;
   assign bus.sha_message        = msg_q;
   assign bus.sha_initial_hashes = iv_q;

endmodule

// File: tb/tb_btc_double_sha256_ctrl.sv
// tb/tb_btc_double_sha256_ctrl.sv - bench for the double SHA-256 sequencer with a behavioural 66-edge core
module tb_btc_double_sha256_ctrl;

   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [639:0] GEN_HDR = 640'h01000000_0000000000000000000000000000000000000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
   localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   btc_double_sha256_ctrl_if bus ();
   btc_double_sha256_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [255:0] hash;
      logic         met;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha256_compress(input logic [255:0] h_in, input logic [511:0] m);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[511-32*t -: 32];
         else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                   + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      {a, b, c, d, e, f, g, h} = h_in;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
              h_in[127:96] + e, h_in[95:64] + f, h_in[63:32] + g, h_in[31:0] + h};
   endfunction

   function automatic logic [255:0] model_dsha(input logic [639:0] hdr);
      logic [255:0] mid, d1;
      mid = sha256_compress(IV, hdr[639:128]);
      d1  = sha256_compress(mid, {hdr[127:0], 1'b1, 319'b0, 64'd640});
      return sha256_compress(IV, {d1, 1'b1, 191'b0, 64'd256});
   endfunction

   function automatic logic [255:0] byterev(input logic [255:0] d);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[255-8*i -: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [639:0] rand_hdr();
      logic [639:0] r;
      for (int i = 0; i < 20; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Core model: result appears 66 edges after the edge that samples the start pulse; a new pulse restarts it
   logic         core_done = 1'b0;
   logic         inj_done = 1'b0;
   logic [255:0] core_digest = '0;
   logic [255:0] core_res = '0;
   int           core_cnt = 0;
   assign bus.sha_done   = core_done | inj_done;
   assign bus.sha_digest = core_digest;

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            core_done   <= 1'b1;
            core_digest <= core_res;
         end
      end
      if (bus.sha_ready_to_hash === 1'b1) begin
         core_res <= sha256_compress(bus.sha_initial_hashes, bus.sha_message);
         core_cnt <= 65;
      end
   end

   always @(negedge clk) begin
      if (bus.hash_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_unexpected_hash_valid: got hash_out=%h, required no result", bus.hash_out);
         end else begin
            mon_e = sb_q.pop_front();
            n_checks += 2;
            if (bus.hash_out !== mon_e.hash) begin
               n_errors++;
               $display("FAIL sb_hash_out: got %h, required %h", bus.hash_out, mon_e.hash);
            end
            if (bus.target_met !== mon_e.met) begin
               n_errors++;
               $display("FAIL sb_target_met: got %b, required %b", bus.target_met, mon_e.met);
            end
         end
      end
   end

   task automatic begin_job(input logic [639:0] hdr, input logic [255:0] tgt);
      exp_t e;
      e.hash = model_dsha(hdr);
      e.met  = (byterev(e.hash) <= tgt);
      @(negedge clk);
      bus.start = 1'b1; bus.header_in = hdr; bus.target = tgt;
      sb_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic wait_done(input bit scramble, input int inj_a, input int inj_b, input int inj_c,
                            output int edges, output int pulses, output bit timeout);
      edges = 0; pulses = 0; timeout = 1'b0;
      forever begin
         @(negedge clk);
         bus.start = scramble;
         inj_done  = (edges == inj_a) || (edges == inj_b) || (edges == inj_c);
         if (bus.sha_ready_to_hash === 1'b1) pulses++;
         if (bus.hash_valid === 1'b1) break;
         if (edges >= 400) begin timeout = 1'b1; break; end
         if (scramble) bus.header_in = rand_hdr();
         @(posedge clk);
         edges++;
      end
      inj_done = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.header_in = '0; bus.target = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks += 7;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      if (bus.hash_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hash_valid: got %b, required 0", bus.hash_valid); end
      if (bus.target_met !== 1'b0) begin n_errors++; $display("FAIL reset_target_met: got %b, required 0", bus.target_met); end
      if (bus.sha_ready_to_hash !== 1'b0) begin n_errors++; $display("FAIL reset_sha_go: got %b, required 0", bus.sha_ready_to_hash); end
      if (bus.hash_out !== '0) begin n_errors++; $display("FAIL reset_hash_out: got %h, required 0", bus.hash_out); end
      if (bus.sha_message !== '0) begin n_errors++; $display("FAIL reset_sha_message: got %h, required 0", bus.sha_message); end
      if (bus.sha_initial_hashes !== '0) begin n_errors++; $display("FAIL reset_sha_iv: got %h, required 0", bus.sha_initial_hashes); end
      bus.start = 1'b1; bus.header_in = GEN_HDR;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; reset = 1'b0;
      n_checks += 2;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_vs_start_busy: got %b, required 0", bus.busy); end
      if (bus.sha_ready_to_hash !== 1'b0) begin n_errors++; $display("FAIL reset_vs_start_go: got %b, required 0", bus.sha_ready_to_hash); end
   endtask

   task automatic test_genesis();
      int edges, pulses; bit to;
      begin_job(GEN_HDR, {256{1'b1}});
      wait_done(1'b0, -1, -1, -1, edges, pulses, to);
      n_checks += 5;
      if (to) begin n_errors++; $display("FAIL genesis_timeout: got no hash_valid in 400 edges, required one"); end
      if (edges !== 201) begin n_errors++; $display("FAIL genesis_latency: got %0d edges, required 201", edges); end
      if (pulses !== 3) begin n_errors++; $display("FAIL genesis_pulses: got %0d, required 3", pulses); end
      if (bus.hash_out !== GEN_HASH) begin n_errors++; $display("FAIL genesis_hash: got %h, required %h", bus.hash_out, GEN_HASH); end
      if (bus.target_met !== 1'b1) begin n_errors++; $display("FAIL genesis_met_max: got %b, required 1", bus.target_met); end
      begin_job(GEN_HDR, '0);
      wait_done(1'b0, -1, -1, -1, edges, pulses, to);
      n_checks += 3;
      if (to) begin n_errors++; $display("FAIL genesis0_timeout: got no hash_valid in 400 edges, required one"); end
      if (bus.hash_out !== GEN_HASH) begin n_errors++; $display("FAIL genesis0_hash: got %h, required %h", bus.hash_out, GEN_HASH); end
      if (bus.target_met !== 1'b0) begin n_errors++; $display("FAIL genesis_met_zero: got %b, required 0", bus.target_met); end
   endtask

   task automatic test_target_boundary();
      int edges, pulses; bit to;
      logic [255:0] rev;
      rev = byterev(model_dsha('0));
      begin_job('0, rev);
      wait_done(1'b0, -1, -1, -1, edges, pulses, to);
      n_checks += 2;
      if (to) begin n_errors++; $display("FAIL eq_timeout: got no hash_valid in 400 edges, required one"); end
      if (bus.target_met !== 1'b1) begin n_errors++; $display("FAIL target_equal: got %b, required 1", bus.target_met); end
      begin_job('0, rev - 256'd1);
      wait_done(1'b0, -1, -1, -1, edges, pulses, to);
      n_checks += 2;
      if (to) begin n_errors++; $display("FAIL lt_timeout: got no hash_valid in 400 edges, required one"); end
      if (bus.target_met !== 1'b0) begin n_errors++; $display("FAIL target_minus1: got %b, required 0", bus.target_met); end
   endtask

   task automatic test_back_to_back();
      int edges, pulses; bit to;
      exp_t e;
      logic [639:0] hdr_b;
      logic [255:0] tgt;
      tgt = {1'b0, {255{1'b1}}};
      begin_job(rand_hdr(), tgt);
      wait_done(1'b1, -1, -1, -1, edges, pulses, to);
      n_checks += 3;
      if (to) begin n_errors++; $display("FAIL b2b_a_timeout: got no hash_valid in 400 edges, required one"); end
      if (edges !== 201) begin n_errors++; $display("FAIL b2b_a_latency: got %0d edges, required 201", edges); end
      if (pulses !== 3) begin n_errors++; $display("FAIL b2b_a_pulses: got %0d, required 3", pulses); end
      hdr_b = rand_hdr();
      e.hash = model_dsha(hdr_b);
      e.met  = (byterev(e.hash) <= tgt);
      bus.header_in = hdr_b;
      sb_q.push_back(e);
      @(posedge clk);
      wait_done(1'b0, -1, -1, -1, edges, pulses, to);
      n_checks += 3;
      if (to) begin n_errors++; $display("FAIL b2b_b_timeout: got no hash_valid in 400 edges, required one"); end
      if (edges !== 201) begin n_errors++; $display("FAIL b2b_b_latency: got %0d edges, required 201", edges); end
      if (pulses !== 3) begin n_errors++; $display("FAIL b2b_b_pulses: got %0d, required 3", pulses); end
   endtask

   task automatic test_reset_abort();
      int edges, pulses; bit to;
      logic [639:0] hdr_y;
      @(negedge clk);
      bus.start = 1'b1; bus.header_in = rand_hdr(); bus.target = {256{1'b1}};
      @(negedge clk);
      bus.start = 1'b0;
      repeat (80) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks += 2;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
      if (bus.sha_ready_to_hash !== 1'b0) begin n_errors++; $display("FAIL abort_go: got %b, required 0", bus.sha_ready_to_hash); end
      repeat (19) @(negedge clk);
      hdr_y = rand_hdr();
      begin_job(hdr_y, {256{1'b1}});
      wait_done(1'b0, -1, -1, -1, edges, pulses, to);
      n_checks += 3;
      if (to) begin n_errors++; $display("FAIL abort_new_timeout: got no hash_valid in 400 edges, required one"); end
      if (edges !== 201) begin n_errors++; $display("FAIL abort_new_latency: got %0d edges, required 201", edges); end
      if (bus.hash_out !== model_dsha(hdr_y)) begin n_errors++; $display("FAIL abort_new_hash: got %h, required %h", bus.hash_out, model_dsha(hdr_y)); end
   endtask

   task automatic test_spurious_done();
      int edges, pulses; bit to;
      @(negedge clk);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      n_checks += 2;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL idle_done_busy: got %b, required 0", bus.busy); end
      if (bus.sha_ready_to_hash !== 1'b0) begin n_errors++; $display("FAIL idle_done_go: got %b, required 0", bus.sha_ready_to_hash); end
      repeat (3) @(negedge clk);
      begin_job(GEN_HDR, {256{1'b1}});
      wait_done(1'b0, 0, 67, 134, edges, pulses, to);
      n_checks += 4;
      if (to) begin n_errors++; $display("FAIL go_done_timeout: got no hash_valid in 400 edges, required one"); end
      if (edges !== 201) begin n_errors++; $display("FAIL go_done_latency: got %0d edges, required 201", edges); end
      if (pulses !== 3) begin n_errors++; $display("FAIL go_done_pulses: got %0d, required 3", pulses); end
      if (bus.hash_out !== GEN_HASH) begin n_errors++; $display("FAIL go_done_hash: got %h, required %h", bus.hash_out, GEN_HASH); end
   endtask

   initial begin
      test_reset();
      test_genesis();
      test_target_boundary();
      test_back_to_back();
      test_reset_abort();
      test_spurious_done();
      repeat (5) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover: got %0d pending results, required 0", sb_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000 time units, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/btc_double_sha256_ctrl.md
Name: btc_double_sha256_ctrl

Overview:
- Upstream sequencer for the single-block SHA-256 core; computes the Bitcoin double SHA-256 of one 80-byte block header.
- Splits the 640-bit header into two padded 512-bit blocks, chains the block-1 midstate into block 2, then pads the 256-bit result into a third block hashed with the standard IV.
- Drives the core's one-pulse start and consumes its digest/done pulse.
- Reports the final hash and a target comparison to the miner top level.

Parameters:
- SHA_IV, 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, standard initial hash; H0 in [255:224].

Ports:
- clk  in  1  hashing clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle job request; accepted only when busy=0
- header_in  in  640  block header; byte 0 in [639:632]; latched on accepted start
- target  in  256  difficulty target as an unsigned integer
- busy  out  1  job in progress
- hash_out  out  256  final raw digest, H0 in [255:224]
- hash_valid  out  1  one-cycle pulse; hash_out and target_met are valid
- target_met  out  1  byte-reversed hash_out <= target
- sha_ready_to_hash  out  1  one-cycle start pulse to the core
- sha_message  out  512  core message block; word 0 in [511:480]
- sha_initial_hashes  out  256  core IV; H0 in [255:224]
- sha_digest  in  256  core result; H0 in [255:224]
- sha_done  in  1  core one-cycle result-valid pulse

Behaviour:
- Reset: state=IDLE. busy, hash_valid, target_met, sha_ready_to_hash = 0. hash_out, sha_message, sha_initial_hashes, the header latch and the midstate register all = 0.
- FSM states: IDLE, B1_GO, B1_WAIT, B2_GO, B2_WAIT, B3_GO, B3_WAIT.
- IDLE: on start, latch header_in and target; go to B1_GO; busy=1. start while busy is ignored and is not queued.
- B1_GO, 1 cycle:
  - sha_message = header[639:128].
  - sha_initial_hashes = SHA_IV.
  - sha_ready_to_hash = 1.
  - Next state: B1_WAIT.
- B1_WAIT: on sha_done, midstate <= sha_digest; go to B2_GO.
- B2_GO:
  - sha_message = {header[127:0], 1'b1, 319'b0, 64'd640}.
  - sha_initial_hashes = midstate.
  - Pulse sha_ready_to_hash; next state B2_WAIT.
- B2_WAIT: on sha_done, latch sha_digest as d1; go to B3_GO.
- B3_GO:
  - sha_message = {d1, 1'b1, 191'b0, 64'd256}.
  - sha_initial_hashes = SHA_IV.
  - Pulse sha_ready_to_hash; next state B3_WAIT.
- B3_WAIT: on sha_done, in the same edge:
  - hash_out <= sha_digest;
  - target_met <= (byte-reversed sha_digest <= target);
  - hash_valid <= 1 for one cycle;
  - busy <= 0; state <= IDLE.
- A start in the cycle hash_valid is high is accepted, since busy=0 then.
- All outputs are registered. sha_message and sha_initial_hashes are stable from the GO cycle until the next GO.
- The core holds its inputs only at the sampling edge; the controller keeps them stable anyway.
- sha_done is ignored outside the WAIT states. The core has no reset, so a power-up X or stale pulse must not advance the FSM.
- Latency, at core latency 66 edges from pulse-sample to done:
  - hash_valid goes high 201 edges after the edge that samples start (67 per block).
  - The controller never counts cycles; it advances only on sha_done.
- Byte reverse: byte i of the digest maps to byte 31-i. The compare is 256-bit unsigned.
- Reset mid-job: FSM returns to IDLE at once and the latched job is discarded. The core may finish, but its done pulse is ignored in IDLE. The next start re-pulses the core, which reinitialises it, so no stale done can reach a new job's WAIT state.
- Simultaneous reset and start: reset wins.
- Simultaneous sha_done and reset: reset wins; no hash_valid.

Decomposition:
- Shared package (btc_pkg): SHA_IV, the padding length constants (640, 256), the state enum, and the byte-reverse function.
- One natural sub-module: btc_block_padder. It is combinational and produces the block-2 and block-3 messages from the header tail and d1.
- Register the padder outputs in the controller.

Test Plan:
- Genesis header 0100000000…3ba3edfd…29ab5f49ffff001d1dac2b7c, target=2^256-1 -> hash_valid after 201 edges; hash_out=6fe28c0a…68d61900000000 00; target_met=1.
- Same header, target=0 -> identical hash_out; target_met=0.
- Header of all zeros, target = byte-reversed expected hash -> target_met=1 (equality boundary). Same header with target = expected-1 -> target_met=0.
- start pulsed every cycle during a job -> exactly 3 sha_ready_to_hash pulses and one hash_valid; the second job starts only at the first start with busy=0.
- reset asserted at B2_WAIT, then start with a new header 20 cycles later -> no hash_valid for the aborted job; new hash correct; the aborted job's sha_done is ignored.
- Spurious sha_done in IDLE and in the GO states -> no state change; hash_valid stays 0.
